// File: rtl/pc_flow_pkg.sv
// Shared types for pc_flow_ctrl: request kinds, next-PC selects, exception causes and FSM states.
// The exception states exist only when PCFLOW_EXC_EN is defined.
package pc_flow_pkg;

    typedef enum logic [2:0] {
        REQ_SEQ  = 3'd0,
        REQ_JUMP = 3'd1,
        REQ_JR   = 3'd2,
        REQ_BEQ  = 3'd3,
        REQ_BNE  = 3'd4,
        REQ_BGT  = 3'd5,
        REQ_BLE  = 3'd6,
        REQ_RTE  = 3'd7
    } req_kind_e;

    localparam logic [2:0] SEL_ALU     = 3'b000;
    localparam logic [2:0] SEL_ALU_OUT = 3'b001;
    localparam logic [2:0] SEL_JUMP    = 3'b010;
    localparam logic [2:0] SEL_VEC     = 3'b011;
    localparam logic [2:0] SEL_EPC     = 3'b100;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_OPCODE = 2'd1,
        CAUSE_OVF    = 2'd2,
        CAUSE_DIV0   = 2'd3
    } exc_cause_e;

    typedef enum logic [2:0] {
        IDLE,
        FLOW
`ifdef PCFLOW_EXC_EN
        , EXC_EPC,
        EXC_WAIT,
        EXC_LOAD
`endif
    } state_e;

    function automatic logic [2:0] kind_to_sel(input req_kind_e kind);
        case (kind)
            REQ_SEQ, REQ_JR: kind_to_sel = SEL_ALU;
            REQ_JUMP:        kind_to_sel = SEL_JUMP;
            REQ_RTE:         kind_to_sel = SEL_EPC;
            default:         kind_to_sel = SEL_ALU_OUT;
        endcase
    endfunction

endpackage

// File: rtl/pc_flow_ctrl.sv
// Next-PC flow controller: flow requests complete one cycle after acceptance; exceptions run EPC, MEM_LAT wait, load.
// Inputs are ignored while busy (no queuing); exception path built only with PCFLOW_EXC_EN defined.
module pc_flow_ctrl
    import pc_flow_pkg::*;
#(
    parameter int         MEM_LAT  = 2,
    parameter logic [7:0] VEC_BASE = 8'd253
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_kind,
    input  logic       zero,
    input  logic       gt,
    input  logic       exc_opcode,
    input  logic       exc_ovf,
    input  logic       exc_div0,
    output logic [2:0] pc_src_sel,
    output logic       pc_write,
    output logic       epc_write,
    output logic       exc_mem_rd,
    output logic [7:0] vec_addr,
    output logic [1:0] exc_cause,
    output logic       busy,
    output logic       done
);

    state_e     state_q, state_d;
    req_kind_e  kind_q, kind_d;
    logic       zero_q, zero_d;
    logic       gt_q, gt_d;
    logic [2:0] sel_q, sel_d;

`ifdef PCFLOW_EXC_EN
    localparam logic [2:0] WAIT_LAST = 3'(MEM_LAT - 1);

    exc_cause_e cause_q, cause_d, cause_new;
    logic [7:0] vec_q, vec_d;
    logic [2:0] cnt_q, cnt_d;
    logic       exc_any;

    assign exc_any = exc_opcode | exc_ovf | exc_div0;

    always_comb begin
        if (exc_opcode)   cause_new = CAUSE_OPCODE;
        else if (exc_ovf) cause_new = CAUSE_OVF;
        else              cause_new = CAUSE_DIV0;
    end
`else
    logic unused_exc;
    assign unused_exc = ^{exc_opcode, exc_ovf, exc_div0, VEC_BASE, 3'(MEM_LAT)};
`endif

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        zero_d  = zero_q;
        gt_d    = gt_q;
        sel_d   = sel_q;
`ifdef PCFLOW_EXC_EN
        cause_d = cause_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef PCFLOW_EXC_EN
                // An exception wins over a same-cycle request, which is dropped.
                if (exc_any) begin
                    state_d = EXC_EPC;
                    cause_d = cause_new;
                    vec_d   = VEC_BASE + {6'd0, cause_new} - 8'd1;
                end else
`endif
                if (req_valid) begin
                    state_d = FLOW;
                    kind_d  = req_kind_e'(req_kind);
                    zero_d  = zero;
                    gt_d    = gt;
                    sel_d   = kind_to_sel(req_kind_e'(req_kind));
                end
            end
            FLOW: state_d = IDLE;
`ifdef PCFLOW_EXC_EN
            EXC_EPC: begin
                state_d = EXC_WAIT;
                cnt_d   = 3'd0;
            end
            EXC_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = EXC_LOAD;
                    sel_d   = SEL_VEC;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            EXC_LOAD: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            kind_q  <= REQ_SEQ;
            zero_q  <= 1'b0;
            gt_q    <= 1'b0;
            sel_q   <= SEL_ALU;
`ifdef PCFLOW_EXC_EN
            cause_q <= CAUSE_NONE;
            vec_q   <= 8'd0;
            cnt_q   <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            zero_q  <= zero_d;
            gt_q    <= gt_d;
            sel_q   <= sel_d;
`ifdef PCFLOW_EXC_EN
            cause_q <= cause_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        pc_write = 1'b0;
        done     = 1'b0;
        case (state_q)
            FLOW: begin
                done = 1'b1;
                case (kind_q)
                    REQ_BEQ: pc_write = zero_q;
                    REQ_BNE: pc_write = ~zero_q;
                    REQ_BGT: pc_write = gt_q;
                    REQ_BLE: pc_write = ~gt_q;
                    default: pc_write = 1'b1;
                endcase
            end
`ifdef PCFLOW_EXC_EN
            EXC_LOAD: begin
                pc_write = 1'b1;
                done     = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign pc_src_sel = sel_q;

`ifdef PCFLOW_EXC_EN
    assign epc_write  = (state_q == EXC_EPC);
    assign exc_mem_rd = (state_q == EXC_EPC) || (state_q == EXC_WAIT);
    assign vec_addr   = vec_q;
    assign exc_cause  = cause_q;
`else
    assign epc_write  = 1'b0;
    assign exc_mem_rd = 1'b0;
    assign vec_addr   = 8'd0;
    assign exc_cause  = 2'd0;
`endif

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Bench for pc_flow_ctrl: directed scenarios then randomized traffic against a transaction-level plan model.
// Honours PCFLOW_EXC_EN the same way the design does.
module tb_pc_flow_ctrl;

    localparam int         MEM_LAT  = 2;
    localparam logic [7:0] VEC_BASE = 8'd253;
`ifdef PCFLOW_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [2:0] req_kind;
    logic       zero, gt;
    logic       exc_opcode, exc_ovf, exc_div0;
    logic [2:0] pc_src_sel;
    logic       pc_write, epc_write, exc_mem_rd;
    logic [7:0] vec_addr;
    logic [1:0] exc_cause;
    logic       busy, done;

    pc_flow_ctrl #(.MEM_LAT(MEM_LAT), .VEC_BASE(VEC_BASE)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_kind(req_kind),
        .zero(zero), .gt(gt), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf),
        .exc_div0(exc_div0), .pc_src_sel(pc_src_sel), .pc_write(pc_write),
        .epc_write(epc_write), .exc_mem_rd(exc_mem_rd), .vec_addr(vec_addr),
        .exc_cause(exc_cause), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        bit         sel_chk;
        logic       pcw, epc, rd;
        logic [7:0] vec;
        bit         vec_chk;
        logic [1:0] cause;
        logic       busy, done;
    } exp_t;

    exp_t       plan[$];
    logic [2:0] m_sel;
    logic [1:0] m_cause;
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] sel, input bit sel_chk, input logic pcw,
                                input logic epc, input logic rd, input logic [7:0] vec,
                                input bit vec_chk, input logic [1:0] cause,
                                input logic bsy, input logic dn);
        exp_t e;
        e.sel = sel; e.sel_chk = sel_chk; e.pcw = pcw; e.epc = epc; e.rd = rd;
        e.vec = vec; e.vec_chk = vec_chk; e.cause = cause; e.busy = bsy; e.done = dn;
        return e;
    endfunction

    // Push the per-cycle outputs a newly accepted transaction must produce.
    task automatic accept(input logic v, input logic [2:0] k, input logic z, input logic g,
                          input logic eo, input logic eov, input logic ed);
        logic [2:0] sel;
        logic       pcw;
        logic [1:0] c;
        logic [7:0] va;
        if (EXC_EN && (eo || eov || ed)) begin
            c  = eo ? 2'd1 : (eov ? 2'd2 : 2'd3);
            va = VEC_BASE + {6'd0, c} - 8'd1;
            m_cause = c;
            plan.push_back(mk(m_sel, 1'b0, 1'b0, 1'b1, 1'b1, va, 1'b1, c, 1'b1, 1'b0));
            for (int i = 0; i < MEM_LAT; i++)
                plan.push_back(mk(m_sel, 1'b0, 1'b0, 1'b0, 1'b1, va, 1'b1, c, 1'b1, 1'b0));
            plan.push_back(mk(3'b011, 1'b1, 1'b1, 1'b0, 1'b0, va, 1'b1, c, 1'b1, 1'b1));
            m_sel = 3'b011;
        end else if (v) begin
            case (k)
                3'd0, 3'd2: sel = 3'b000;
                3'd1:       sel = 3'b010;
                3'd7:       sel = 3'b100;
                default:    sel = 3'b001;
            endcase
            case (k)
                3'd3:    pcw = z;
                3'd4:    pcw = !z;
                3'd5:    pcw = g;
                3'd6:    pcw = !g;
                default: pcw = 1'b1;
            endcase
            plan.push_back(mk(sel, 1'b1, pcw, 1'b0, 1'b0, 8'd0, !EXC_EN, m_cause, 1'b1, 1'b1));
            m_sel = sel;
        end
    endtask

    task automatic check_outputs(input exp_t e);
        chk("busy", {7'd0, busy}, {7'd0, e.busy});
        chk("done", {7'd0, done}, {7'd0, e.done});
        chk("pc_write", {7'd0, pc_write}, {7'd0, e.pcw});
        chk("epc_write", {7'd0, epc_write}, {7'd0, e.epc});
        chk("exc_mem_rd", {7'd0, exc_mem_rd}, {7'd0, e.rd});
        chk("exc_cause", {6'd0, exc_cause}, {6'd0, e.cause});
        if (e.sel_chk) chk("pc_src_sel", {5'd0, pc_src_sel}, {5'd0, e.sel});
        if (e.vec_chk) chk("vec_addr", vec_addr, e.vec);
    endtask

    task automatic step(input logic v, input logic [2:0] k, input logic z, input logic g,
                        input logic eo, input logic eov, input logic ed);
        exp_t e;
        bit   idle;
        @(negedge clk);
        idle = (plan.size() == 0);
        if (idle) e = mk(m_sel, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, !EXC_EN, m_cause, 1'b0, 1'b0);
        else      e = plan.pop_front();
        check_outputs(e);
        req_valid = v; req_kind = k; zero = z; gt = g;
        exc_opcode = eo; exc_ovf = eov; exc_div0 = ed;
        if (idle) accept(v, k, z, g, eo, eov, ed);
    endtask

    task automatic drive_zero();
        req_valid = 1'b0; req_kind = 3'd0; zero = 1'b0; gt = 1'b0;
        exc_opcode = 1'b0; exc_ovf = 1'b0; exc_div0 = 1'b0;
    endtask

    task automatic check_reset_vals();
        plan.delete();
        m_sel   = 3'b000;
        m_cause = 2'd0;
        check_outputs(mk(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 2'd0, 1'b0, 1'b0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive_zero();
        #1;
        check_reset_vals();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive_zero();
        #2;
        check_reset_vals();
        @(negedge clk);
        reset = 1'b0;

        // BEQ taken, BNE not taken
        step(1, 3'd3, 1, 0, 0, 0, 0);
        step(0, 3'd0, 0, 0, 0, 0, 0);
        step(1, 3'd4, 1, 0, 0, 0, 0);
        step(0, 3'd0, 0, 0, 0, 0, 0);
        // overflow and div0 together: overflow wins
        step(0, 3'd0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 3'd0, 0, 0, 0, 0, 0);
        // JUMP dropped in favour of opcode exception
        step(1, 3'd1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 3'd0, 0, 0, 0, 0, 0);
        // RTE alongside div0
        step(1, 3'd7, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 3'd0, 0, 0, 0, 0, 0);
        // reset in the middle of an exception wait
        step(0, 3'd0, 0, 0, 0, 0, 1);
        step(0, 3'd0, 0, 0, 0, 0, 0);
        step(0, 3'd0, 0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 3'd0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 11) == 0),
                     1'($urandom_range(0, 11) == 0));
            end
        end
        for (int i = 0; i < 12; i++) step(0, 3'd0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
